// File: rtl/jpeg_dezigzag_buffer.sv
// Zigzag-to-raster reorder buffer for 8x8 coefficient blocks, ping-pong over two 64-entry banks.
// Optional start-of-block checking is enabled by defining JPEG_DEZIGZAG_SOB_CHECK_EN.
module jpeg_dezigzag_buffer #(
  parameter int DW    = 12,
  parameter int NBANK = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [5:0]    out_idx,
  output logic          out_last
`ifdef JPEG_DEZIGZAG_SOB_CHECK_EN
  ,
  input  logic          in_sob,
  output logic          sync_err
`endif
);

  // Raster position of each zigzag scan index.
  localparam logic [0:63][5:0] ZZ = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [DW-1:0] mem [NBANK*64];
  logic [5:0]    wr_cnt, rd_cnt;
  logic          wr_bank, rd_bank;
  logic [1:0]    full;

  logic          wr_fire, rd_fire;
  logic [5:0]    wr_raster, wr_cnt_nxt;
  logic          wr_wrap;

  assign in_ready  = ~rst & ~full[wr_bank];
  assign out_valid = ~rst & full[rd_bank];
  assign out_data  = mem[{rd_bank, rd_cnt}];
  assign out_idx   = rst ? 6'd0 : rd_cnt;
  assign out_last  = out_valid & (rd_cnt == 6'd63);

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  always_comb begin
    wr_raster  = ZZ[wr_cnt];
    wr_cnt_nxt = wr_cnt + 6'd1;
    wr_wrap    = (wr_cnt == 6'd63);
`ifdef JPEG_DEZIGZAG_SOB_CHECK_EN
    // A start marker mid-block abandons the partial block and restarts at index 0.
    if (in_sob && (wr_cnt != 6'd0)) begin
      wr_raster  = 6'd0;
      wr_cnt_nxt = 6'd1;
      wr_wrap    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_raster}] <= in_data;
  end

  // Write and read completions always target different banks, so both full-bit updates can land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt_nxt;
        if (wr_wrap) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 6'd1;
        if (rd_cnt == 6'd63) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

`ifdef JPEG_DEZIGZAG_SOB_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err <= 1'b0;
    end else if (wr_fire && ((in_sob && wr_cnt != 6'd0) || (!in_sob && wr_cnt == 6'd0))) begin
      sync_err <= 1'b1;
    end
  end
`endif

endmodule
